retire_rat: RTL and testbench

//  Commit-side retirement RAT; the producer end of the PRF's free-list/valid interface.
//  Per retired instruction it: records arch->phys mapping; marks new phys valid in PRF (valid_we);

---
 rtl/rename_pkg.sv | 19 +
 rtl/retire_rat_if.sv | 44 ++++
 rtl/free_return_q.sv | 50 +++++
 rtl/retire_rat.sv | 124 ++++++++++++
 tb/tb_retire_rat.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/rename_pkg.sv
// Shared rename types: register index widths, return-queue depth and the
// retirement RAT state encoding.
package rename_pkg;

  localparam int PHYS_REG_BITS = 6;
  localparam int ARCH_REG_BITS = 5;
  localparam int FREE_Q_DEPTH  = 4;
  localparam int ARCH_REGS     = 1 << ARCH_REG_BITS;

  typedef logic [PHYS_REG_BITS-1:0] phys_reg_t;
  typedef logic [ARCH_REG_BITS-1:0] arch_reg_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESTORE = 2'd1,
    DONE    = 2'd2
  } retire_rat_state_t;

endpackage

// File: rtl/retire_rat_if.sv
// Bundle between the retirement RAT (slave) and its environment (master):
// commit port, PRF valid write, free-list return, flush/restore and FSM state.
interface retire_rat_if;
  import rename_pkg::*;

  // Handshakes (commit, free_push): a transfer happens on a rising clk edge where
  // valid && ready; the source holds valid and data stable until then, and ready
  // never depends combinationally on valid.
  logic              commit_valid;
  logic              commit_ready;
  arch_reg_t         commit_arch;
  phys_reg_t         commit_phys;

  logic              valid_we;
  phys_reg_t         commit_rd_s;
  logic              rd_valid;

  logic              free_push_valid;
  logic              free_push_ready;
  phys_reg_t         free_push_data;

  logic              flush;
  logic              restore_valid;
  arch_reg_t         restore_arch;
  phys_reg_t         restore_phys;
  logic              restore_done;

  retire_rat_state_t state;

  modport master (
    output commit_valid, commit_arch, commit_phys, free_push_ready, flush,
    input  commit_ready, valid_we, commit_rd_s, rd_valid,
    input  free_push_valid, free_push_data,
    input  restore_valid, restore_arch, restore_phys, restore_done, state
  );

  modport slave (
    input  commit_valid, commit_arch, commit_phys, free_push_ready, flush,
    output commit_ready, valid_we, commit_rd_s, rd_valid,
    output free_push_valid, free_push_data,
    output restore_valid, restore_arch, restore_phys, restore_done, state
  );

endinterface

// File: rtl/free_return_q.sv
// Small circular FIFO holding freed physical registers until the free list
// takes them; head entry is presented with a valid/ready pop interface.
module free_return_q #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop_ready,
  output logic                     pop_valid,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             pop;

  assign pop_valid = (count != '0);
  assign pop_data  = mem[rd_ptr];
  assign pop       = pop_valid && pop_ready;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/retire_rat.sv
// Commit-side retirement RAT: records committed arch->phys mappings, strobes PRF
// valid bits, returns displaced phys regs, and replays the map after a flush.
module retire_rat
  import rename_pkg::*;
(
  input logic         clk,
  input logic         rst_n,
  retire_rat_if.slave bus
);

  localparam int        QCW       = $clog2(FREE_Q_DEPTH) + 1;
  localparam arch_reg_t ARCH_ZERO = '0;
  localparam arch_reg_t ARCH_LAST = '1;

  phys_reg_t         map_q [ARCH_REGS];
  retire_rat_state_t state;
  arch_reg_t         idx;
  arch_reg_t         idx_next;
  logic [QCW-1:0]    q_count;
  logic              commit_ready;
  logic              accept;
  logic              enq;
  phys_reg_t         old_phys;

  logic              valid_we_q;
  logic              rd_valid_q;
  phys_reg_t         commit_rd_s_q;
  logic              restore_valid_q;
  phys_reg_t         restore_phys_q;
  logic              restore_done_q;

  assign commit_ready = rst_n && (state == IDLE) && (q_count < QCW'(FREE_Q_DEPTH));
  assign accept       = bus.commit_valid && commit_ready;
  assign enq          = accept && (bus.commit_arch != ARCH_ZERO);
  assign old_phys     = map_q[bus.commit_arch];
  assign idx_next     = idx + arch_reg_t'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ARCH_REGS; i++) map_q[i] <= phys_reg_t'(i);
    end else if (enq) begin
      map_q[bus.commit_arch] <= bus.commit_phys;
    end
  end

  // Arch 0 still marks its phys valid even though it never enters the map.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_we_q    <= 1'b0;
      rd_valid_q    <= 1'b0;
      commit_rd_s_q <= '0;
    end else begin
      valid_we_q    <= accept;
      rd_valid_q    <= accept;
      commit_rd_s_q <= accept ? bus.commit_phys : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      idx             <= '0;
      restore_valid_q <= 1'b0;
      restore_phys_q  <= '0;
      restore_done_q  <= 1'b0;
    end else if (bus.flush) begin
      // map[0] is never written, so a same-cycle commit cannot change entry 0;
      // later entries are read after that commit has landed.
      state           <= RESTORE;
      idx             <= '0;
      restore_valid_q <= 1'b1;
      restore_phys_q  <= map_q[ARCH_ZERO];
      restore_done_q  <= 1'b0;
    end else begin
      case (state)
        RESTORE: begin
          if (idx == ARCH_LAST) begin
            state           <= DONE;
            idx             <= '0;
            restore_valid_q <= 1'b0;
            restore_phys_q  <= '0;
            restore_done_q  <= 1'b1;
          end else begin
            idx            <= idx_next;
            restore_phys_q <= map_q[idx_next];
          end
        end
        DONE: begin
          state          <= IDLE;
          restore_done_q <= 1'b0;
        end
        default: begin
          state          <= IDLE;
          restore_done_q <= 1'b0;
        end
      endcase
    end
  end

  free_return_q #(
    .WIDTH (PHYS_REG_BITS),
    .DEPTH (FREE_Q_DEPTH)
  ) u_free_q (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (enq),
    .push_data (old_phys),
    .pop_ready (bus.free_push_ready),
    .pop_valid (bus.free_push_valid),
    .pop_data  (bus.free_push_data),
    .count     (q_count)
  );

  assign bus.commit_ready  = commit_ready;
  assign bus.valid_we      = valid_we_q;
  assign bus.rd_valid      = rd_valid_q;
  assign bus.commit_rd_s   = commit_rd_s_q;
  assign bus.restore_valid = restore_valid_q;
  assign bus.restore_arch  = idx;
  assign bus.restore_phys  = restore_phys_q;
  assign bus.restore_done  = restore_done_q;
  assign bus.state         = state;

endmodule

// File: tb/tb_retire_rat.sv
// Directed bench for retire_rat: commit path, return queue ordering/back-pressure,
// flush replay, aborted replay and asynchronous reset during replay.
module tb_retire_rat;
  import rename_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  phys_reg_t                exp_map [ARCH_REGS];
  logic [PHYS_REG_BITS-1:0] exp_q [$];

  retire_rat_if bus ();

  retire_rat dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic commit(input int arch, input int phys);
    bus.commit_valid = 1'b1;
    bus.commit_arch  = arch_reg_t'(arch);
    bus.commit_phys  = phys_reg_t'(phys);
  endtask

  task automatic drain(input string tag, input int n);
    bus.free_push_ready = 1'b1;
    for (int k = 0; k < n; k++) begin
      chk({tag, "_free_valid"}, 32'(bus.free_push_valid), 1);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $error("FAIL %s_free_order observed=%0d expected=none", tag, bus.free_push_data);
      end else begin
        chk({tag, "_free_data"}, 32'(bus.free_push_data), 32'(exp_q.pop_front()));
      end
      step();
    end
    bus.free_push_ready = 1'b0;
    chk({tag, "_free_empty"}, 32'(bus.free_push_valid), 0);
  endtask

  // Entered with entry 0 on the outputs; abort_at >= 0 re-flushes at that index.
  task automatic restore_pass(input string tag, input int abort_at);
    for (int i = 0; i < ARCH_REGS; i++) begin
      chk({tag, "_rvalid"}, 32'(bus.restore_valid), 1);
      chk({tag, "_rarch"},  32'(bus.restore_arch), i);
      chk({tag, "_rphys"},  32'(bus.restore_phys), 32'(exp_map[i]));
      chk({tag, "_rdone_early"}, 32'(bus.restore_done), 0);
      if (i == abort_at) begin
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        return;
      end
      step();
    end
    chk({tag, "_done"},       32'(bus.restore_done), 1);
    chk({tag, "_done_valid"}, 32'(bus.restore_valid), 0);
    chk({tag, "_done_state"}, 32'(bus.state), 32'(DONE));
    step();
    chk({tag, "_done_pulse"}, 32'(bus.restore_done), 0);
    chk({tag, "_idle_ready"}, 32'(bus.commit_ready), 1);
  endtask

  initial begin
    bus.commit_valid    = 1'b0;
    bus.commit_arch     = '0;
    bus.commit_phys     = '0;
    bus.free_push_ready = 1'b0;
    bus.flush           = 1'b0;
    for (int i = 0; i < ARCH_REGS; i++) exp_map[i] = phys_reg_t'(i);

    // Reset values
    #1;
    chk("rst_ready",   32'(bus.commit_ready), 0);
    chk("rst_we",      32'(bus.valid_we), 0);
    chk("rst_free",    32'(bus.free_push_valid), 0);
    chk("rst_rvalid",  32'(bus.restore_valid), 0);
    chk("rst_rdone",   32'(bus.restore_done), 0);
    chk("rst_state",   32'(bus.state), 32'(IDLE));
    repeat (2) @(posedge clk);
    #4 rst_n = 1'b1;
    step();
    chk("post_rst_ready", 32'(bus.commit_ready), 1);

    // T1: identity map dump
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    chk("t1_ready_low", 32'(bus.commit_ready), 0);
    restore_pass("t1", -1);

    // T2: single commit
    commit(5, 40);
    exp_map[5] = 6'd40;
    exp_q.push_back(6'd5);
    step();
    bus.commit_valid = 1'b0;
    chk("t2_we",    32'(bus.valid_we), 1);
    chk("t2_rd_s",  32'(bus.commit_rd_s), 40);
    chk("t2_rdval", 32'(bus.rd_valid), 1);
    step();
    chk("t2_we_pulse", 32'(bus.valid_we), 0);
    drain("t2", 1);

    // T3: back-to-back commits to the same arch reg
    commit(7, 33);
    exp_q.push_back(6'd7);
    step();
    chk("t3_rd_s_a", 32'(bus.commit_rd_s), 33);
    commit(7, 34);
    exp_map[7] = 6'd34;
    exp_q.push_back(6'd33);
    step();
    bus.commit_valid = 1'b0;
    chk("t3_rd_s_b", 32'(bus.commit_rd_s), 34);
    drain("t3", 2);

    // T4: fill the return queue with the free list stalled
    for (int k = 0; k < FREE_Q_DEPTH; k++) begin
      chk("t4_ready", 32'(bus.commit_ready), 1);
      commit(k + 1, 41 + k);
      exp_map[k + 1] = phys_reg_t'(41 + k);
      exp_q.push_back(phys_reg_t'(k + 1));
      step();
    end
    chk("t4_full", 32'(bus.commit_ready), 0);
    commit(6, 45);
    step();
    chk("t4_blocked_we", 32'(bus.valid_we), 0);
    chk("t4_still_full", 32'(bus.commit_ready), 0);
    bus.commit_valid = 1'b0;
    drain("t4", 4);
    chk("t4_ready_back", 32'(bus.commit_ready), 1);

    // T5: arch 0 commit
    commit(0, 50);
    step();
    bus.commit_valid = 1'b0;
    chk("t5_we",   32'(bus.valid_we), 1);
    chk("t5_rd_s", 32'(bus.commit_rd_s), 50);
    chk("t5_free", 32'(bus.free_push_valid), 0);

    // Enqueue and pop in the same cycle
    bus.free_push_ready = 1'b1;
    commit(9, 51);
    exp_map[9] = 6'd51;
    step();
    chk("sim_data_a",  32'(bus.free_push_data), 9);
    commit(10, 52);
    exp_map[10] = 6'd52;
    step();
    bus.commit_valid = 1'b0;
    chk("sim_valid",   32'(bus.free_push_valid), 1);
    chk("sim_data_b",  32'(bus.free_push_data), 10);
    chk("sim_rd_s",    32'(bus.commit_rd_s), 52);
    step();
    chk("sim_empty",   32'(bus.free_push_valid), 0);

    // T6: commit and flush together, abort at idx 10, then full pass
    commit(11, 53);
    exp_map[11] = 6'd53;
    bus.flush = 1'b1;
    step();
    bus.commit_valid = 1'b0;
    bus.flush        = 1'b0;
    chk("t6_we",         32'(bus.valid_we), 1);
    chk("t6_rd_s",       32'(bus.commit_rd_s), 53);
    chk("t6_free_valid", 32'(bus.free_push_valid), 1);
    chk("t6_free_data",  32'(bus.free_push_data), 11);
    restore_pass("t6a", 10);
    chk("t6_drained", 32'(bus.free_push_valid), 0);
    bus.free_push_ready = 1'b0;
    restore_pass("t6b", -1);

    // Reset in the middle of a replay
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    repeat (3) step();
    chk("mid_arch", 32'(bus.restore_arch), 3);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rvalid", 32'(bus.restore_valid), 0);
    chk("mid_rst_rarch",  32'(bus.restore_arch), 0);
    chk("mid_rst_rphys",  32'(bus.restore_phys), 0);
    chk("mid_rst_rdone",  32'(bus.restore_done), 0);
    chk("mid_rst_we",     32'(bus.valid_we), 0);
    chk("mid_rst_ready",  32'(bus.commit_ready), 0);
    chk("mid_rst_state",  32'(bus.state), 32'(IDLE));
    #3 rst_n = 1'b1;
    step();
    chk("post_mid_rdone", 32'(bus.restore_done), 0);
    chk("post_mid_ready", 32'(bus.commit_ready), 1);
    for (int i = 0; i < ARCH_REGS; i++) exp_map[i] = phys_reg_t'(i);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    restore_pass("t7", -1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
